issue_stall_counter_bank: RTL and testbench



---
 rtl/issue_stall_counter_bank.sv | 200 ++++++++++++++++++++
 tb/tb_issue_stall_counter_bank.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/issue_stall_counter_bank.sv
// Issue-stage stall profiler counter bank.
// Each stall cycle (en_i & ~ack_i) is attributed to exactly one reason. The
// lowest set flag wins when lo_to_hi_p=1, and the highest set flag wins
// otherwise. A stall with no flag set counts as "unknown". Counters saturate
// and do not wrap.
// A shadow bank holds snapshots of the live bank and is read through a
// one-cycle-latency indexed port.
// Optional: define STALL_PROF_RUNLEN_EN to track the longest contiguous stall
// run and the reason attributed to its first cycle. These are readable at
// reasons_p+3 and reasons_p+4.
// Ports:
//   clk_i, reset_i      clock, synchronous active-high reset
//   en_i                counting enable
//   clear_i             zero the live bank and sat_o
//   snapshot_i          copy the pre-update live bank into the shadow bank
//   ack_i               issue stage accepted an instruction this cycle
//   reason_i            per-cycle stall-reason flags
//   rd_v_i, rd_addr_i   read request and shadow index
//   rd_v_o, rd_data_o   read response, valid one cycle after the request
//   sat_o               sticky per-counter saturation flags of the live bank
module issue_stall_counter_bank #(
  parameter int unsigned width_p      = 64,
  parameter int unsigned reasons_p    = 35,
  parameter int unsigned lo_to_hi_p   = 1,
  parameter int unsigned addr_width_p = 6
) (
  input  logic                    clk_i,
  input  logic                    reset_i,
  input  logic                    en_i,
  input  logic                    clear_i,
  input  logic                    snapshot_i,
  input  logic                    ack_i,
  input  logic [reasons_p-1:0]    reason_i,
  input  logic                    rd_v_i,
  input  logic [addr_width_p-1:0] rd_addr_i,
  output logic                    rd_v_o,
  output logic [width_p-1:0]      rd_data_o,
  output logic [reasons_p+2:0]    sat_o
);

  localparam int unsigned NumCnt = reasons_p + 3;
  localparam int unsigned IdxUnk = reasons_p;
  localparam int unsigned IdxTot = reasons_p + 1;
  localparam int unsigned IdxIss = reasons_p + 2;
  localparam int unsigned IdxW   = $clog2(reasons_p + 1);
  localparam logic [width_p-1:0] CntMax = '1;

  logic stall_c;
  logic issue_c;
  logic any_reason_c;
  logic [IdxW-1:0] win_idx_c;
  logic [NumCnt-1:0] inc_c;

  logic [width_p-1:0] live_q   [NumCnt];
  logic [width_p-1:0] live_d   [NumCnt];
  logic [width_p-1:0] shadow_q [NumCnt];
  logic [NumCnt-1:0]  sat_q, sat_d;
  logic               rd_v_q;
  logic [width_p-1:0] rd_data_q, rd_data_d;

  assign stall_c = en_i & ~ack_i;
  assign issue_c = en_i & ack_i;

  // Priority encoder: the final assignment in scan order wins.
  always_comb begin
    win_idx_c    = '0;
    any_reason_c = |reason_i;
    if (lo_to_hi_p != 0) begin
      for (int i = int'(reasons_p) - 1; i >= 0; i--) begin
        if (reason_i[i]) win_idx_c = IdxW'(i);
      end
    end else begin
      for (int i = 0; i < int'(reasons_p); i++) begin
        if (reason_i[i]) win_idx_c = IdxW'(i);
      end
    end
  end

  // Per-counter increment requests.
  always_comb begin
    inc_c = '0;
    for (int i = 0; i < int'(reasons_p); i++) begin
      inc_c[i] = stall_c & any_reason_c & (win_idx_c == IdxW'(i));
    end
    inc_c[IdxUnk] = stall_c & ~any_reason_c;
    inc_c[IdxTot] = stall_c;
    inc_c[IdxIss] = issue_c;
  end

  // Live bank next state: clear wins, and a counter at max holds and flags saturation.
  always_comb begin
    for (int k = 0; k < int'(NumCnt); k++) begin
      live_d[k] = live_q[k];
      sat_d[k]  = sat_q[k];
      if (clear_i) begin
        live_d[k] = '0;
        sat_d[k]  = 1'b0;
      end else if (inc_c[k]) begin
        if (live_q[k] == CntMax) begin
          sat_d[k] = 1'b1;
        end else begin
          live_d[k] = live_q[k] + width_p'(1);
        end
      end
    end
  end

`ifdef STALL_PROF_RUNLEN_EN
  logic [IdxW-1:0]    attr_idx_c;
  logic [width_p-1:0] run_len_q, run_len_d;
  logic [IdxW-1:0]    run_rsn_q, run_rsn_d;
  logic [width_p-1:0] max_len_q, max_len_d, shadow_max_len_q;
  logic [IdxW-1:0]    max_rsn_q, max_rsn_d, shadow_max_rsn_q;

  assign attr_idx_c = any_reason_c ? win_idx_c : IdxW'(reasons_p);

  // Run tracking: an issue cycle closes the run, and en_i low only pauses it.
  always_comb begin
    run_len_d = run_len_q;
    run_rsn_d = run_rsn_q;
    max_len_d = max_len_q;
    max_rsn_d = max_rsn_q;
    if (clear_i) begin
      run_len_d = '0;
      run_rsn_d = '0;
      max_len_d = '0;
      max_rsn_d = '0;
    end else if (stall_c) begin
      if (run_len_q == '0) run_rsn_d = attr_idx_c;
      if (run_len_q != CntMax) run_len_d = run_len_q + width_p'(1);
    end else if (issue_c) begin
      if (run_len_q > max_len_q) begin
        max_len_d = run_len_q;
        max_rsn_d = run_rsn_q;
      end
      run_len_d = '0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      run_len_q        <= '0;
      run_rsn_q        <= '0;
      max_len_q        <= '0;
      max_rsn_q        <= '0;
      shadow_max_len_q <= '0;
      shadow_max_rsn_q <= '0;
    end else begin
      run_len_q <= run_len_d;
      run_rsn_q <= run_rsn_d;
      max_len_q <= max_len_d;
      max_rsn_q <= max_rsn_d;
      if (snapshot_i) begin
        shadow_max_len_q <= max_len_q;
        shadow_max_rsn_q <= max_rsn_q;
      end
    end
  end
`endif

  // Read mux over the shadow bank; unmapped indices return zero.
  always_comb begin
    rd_data_d = '0;
    if (rd_v_i) begin
      for (int k = 0; k < int'(NumCnt); k++) begin
        if (rd_addr_i == addr_width_p'(k)) rd_data_d = shadow_q[k];
      end
`ifdef STALL_PROF_RUNLEN_EN
      if (rd_addr_i == addr_width_p'(reasons_p + 3)) rd_data_d = shadow_max_len_q;
      if (rd_addr_i == addr_width_p'(reasons_p + 4)) rd_data_d = width_p'(shadow_max_rsn_q);
`endif
    end
  end

  // Live bank, shadow bank and read response registers.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int k = 0; k < int'(NumCnt); k++) begin
        live_q[k]   <= '0;
        shadow_q[k] <= '0;
      end
      sat_q     <= '0;
      rd_v_q    <= 1'b0;
      rd_data_q <= '0;
    end else begin
      for (int k = 0; k < int'(NumCnt); k++) begin
        live_q[k] <= live_d[k];
        if (snapshot_i) shadow_q[k] <= live_q[k];
      end
      sat_q     <= sat_d;
      rd_v_q    <= rd_v_i;
      rd_data_q <= rd_data_d;
    end
  end

  assign rd_v_o    = rd_v_q;
  assign rd_data_o = rd_data_q;
  assign sat_o     = sat_q;

endmodule

// File: tb/tb_issue_stall_counter_bank.sv
// Directed testbench for issue_stall_counter_bank.
// Three instances share the same stimulus:
//   dut   : lowest set reason wins, 64-bit counters
//   dut_h : highest set reason wins, 64-bit counters
//   dut_w : lowest set reason wins, 4-bit counters
module tb_issue_stall_counter_bank;

  localparam int unsigned R  = 35;
  localparam int unsigned AW = 6;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset, en, clear, snapshot, ack, rd_v;
  logic [R-1:0]  reason;
  logic [AW-1:0] rd_addr;

  logic          rv_a, rv_h, rv_w;
  logic [63:0]   rd_a, rd_h;
  logic [3:0]    rd_w;
  logic [R+2:0]  sat_a, sat_h, sat_w;

  int unsigned n_checks = 0;
  int unsigned n_fail   = 0;

  issue_stall_counter_bank #(.width_p(64), .reasons_p(R), .lo_to_hi_p(1), .addr_width_p(AW)) dut (
    .clk_i(clk), .reset_i(reset), .en_i(en), .clear_i(clear), .snapshot_i(snapshot),
    .ack_i(ack), .reason_i(reason), .rd_v_i(rd_v), .rd_addr_i(rd_addr),
    .rd_v_o(rv_a), .rd_data_o(rd_a), .sat_o(sat_a));

  issue_stall_counter_bank #(.width_p(64), .reasons_p(R), .lo_to_hi_p(0), .addr_width_p(AW)) dut_h (
    .clk_i(clk), .reset_i(reset), .en_i(en), .clear_i(clear), .snapshot_i(snapshot),
    .ack_i(ack), .reason_i(reason), .rd_v_i(rd_v), .rd_addr_i(rd_addr),
    .rd_v_o(rv_h), .rd_data_o(rd_h), .sat_o(sat_h));

  issue_stall_counter_bank #(.width_p(4), .reasons_p(R), .lo_to_hi_p(1), .addr_width_p(AW)) dut_w (
    .clk_i(clk), .reset_i(reset), .en_i(en), .clear_i(clear), .snapshot_i(snapshot),
    .ack_i(ack), .reason_i(reason), .rd_v_i(rd_v), .rd_addr_i(rd_addr),
    .rd_v_o(rv_w), .rd_data_o(rd_w), .sat_o(sat_w));

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic [R-1:0] bit_of(input int i);
    logic [R-1:0] v;
    v    = '0;
    v[i] = 1'b1;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    en = 1'b0; ack = 1'b0; reason = '0; clear = 1'b0;
    snapshot = 1'b0; rd_v = 1'b0; rd_addr = '0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic stall(input int n, input logic [R-1:0] r);
    en = 1'b1; ack = 1'b0; reason = r;
    repeat (n) tick();
    idle();
  endtask

  task automatic issue(input int n, input logic [R-1:0] r);
    en = 1'b1; ack = 1'b1; reason = r;
    repeat (n) tick();
    idle();
  endtask

  task automatic snap();
    snapshot = 1'b1;
    tick();
    snapshot = 1'b0;
  endtask

  task automatic rd(input int addr);
    rd_v    = 1'b1;
    rd_addr = AW'(addr);
    tick();
    rd_v    = 1'b0;
  endtask

  logic [R+2:0] exp_sat;

  initial begin
    reset = 1'b0;
    idle();
    do_reset();

    // Reset state
    check_val("reset_rd_v", 64'(rv_a), 64'd0);
    check_val("reset_rd_data", rd_a, 64'd0);
    check_val("reset_sat", 64'(sat_a), 64'd0);

    // Reasons 3 and 7 together: priority selects one of them
    stall(10, bit_of(3) | bit_of(7));
    snap();
    rd(3);
    check_val("t1_rd_v", 64'(rv_a), 64'd1);
    check_val("t1_lo_r3", rd_a, 64'd10);
    check_val("t1_hi_r3", rd_h, 64'd0);
    check_val("t1_w4_r3", 64'(rd_w), 64'd10);
    rd(7);
    check_val("t1_lo_r7", rd_a, 64'd0);
    check_val("t1_hi_r7", rd_h, 64'd10);
    rd(36);
    check_val("t1_total", rd_a, 64'd10);
    tick();
    check_val("t1_idle_rd_v", 64'(rv_a), 64'd0);
    check_val("t1_idle_rd_data", rd_a, 64'd0);

    // Unknown stalls, and issue cycles with reason_i ignored
    do_reset();
    stall(5, '0);
    issue(4, bit_of(1));
    snap();
    rd(35);
    check_val("t2_unknown", rd_a, 64'd5);
    rd(36);
    check_val("t2_total", rd_a, 64'd5);
    rd(37);
    check_val("t2_issued", rd_a, 64'd4);
    rd(1);
    check_val("t2_r1_ignored", rd_a, 64'd0);

    // Saturation on the 4-bit instance, then clear
    do_reset();
    stall(20, bit_of(0));
    exp_sat     = '0;
    exp_sat[0]  = 1'b1;
    exp_sat[36] = 1'b1;
    check_val("t3_w4_sat", 64'(sat_w), 64'(exp_sat));
    check_val("t3_w64_sat", 64'(sat_a), 64'd0);
    snap();
    rd(0);
    check_val("t3_w4_r0_hold", 64'(rd_w), 64'd15);
    check_val("t3_w64_r0", rd_a, 64'd20);
    rd(36);
    check_val("t3_w4_total_hold", 64'(rd_w), 64'd15);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    check_val("t3_sat_cleared", 64'(sat_w), 64'd0);
    snap();
    rd(0);
    check_val("t3_r0_cleared", 64'(rd_w), 64'd0);

    // Snapshot, clear and a stall in the same cycle
    do_reset();
    stall(6, bit_of(2));
    snapshot = 1'b1; clear = 1'b1;
    stall(1, bit_of(2));
    stall(1, bit_of(2));
    rd(2);
    check_val("t4_shadow_pre_clear", rd_a, 64'd6);
    // A read in the snapshot cycle returns the old shadow value
    snapshot = 1'b1;
    rd(2);
    snapshot = 1'b0;
    check_val("t4_rd_with_snap_old", rd_a, 64'd6);
    rd(2);
    check_val("t4_live_after_clear", rd_a, 64'd1);
    rd(36);
    check_val("t4_total_after_clear", rd_a, 64'd1);
    rd(40);
    check_val("t4_out_of_range", rd_a, 64'd0);

    // Reset aborts a read in flight
    stall(3, bit_of(4));
    snap();
    rd(4);
    check_val("t5_pre_reset_read", rd_a, 64'd3);
    rd_v = 1'b1; rd_addr = AW'(4); reset = 1'b1;
    tick();
    check_val("t5_reset_rd_v", 64'(rv_a), 64'd0);
    check_val("t5_reset_rd_data", rd_a, 64'd0);
    reset = 1'b0; rd_v = 1'b0;
    snap();
    rd(4);
    check_val("t5_after_reset_r4", rd_a, 64'd0);
    rd(36);
    check_val("t5_after_reset_total", rd_a, 64'd0);

    // Stall runs: A of length 3 on reason 5, B of length 8 unknown; en_i low pauses B
    do_reset();
    stall(3, bit_of(5));
    issue(1, '0);
    stall(5, '0);
    tick();
    tick();
    stall(3, '0);
    issue(1, '0);
    snap();
    rd(5);
    check_val("t6_r5", rd_a, 64'd3);
    rd(35);
    check_val("t6_unknown", rd_a, 64'd8);
    rd(36);
    check_val("t6_total", rd_a, 64'd11);
    rd(37);
    check_val("t6_issued", rd_a, 64'd2);
`ifdef STALL_PROF_RUNLEN_EN
    rd(38);
    check_val("t6_max_len", rd_a, 64'd8);
    rd(39);
    check_val("t6_max_reason", rd_a, 64'd35);
`else
    rd(38);
    check_val("t6_max_len_absent", rd_a, 64'd0);
    rd(39);
    check_val("t6_max_reason_absent", rd_a, 64'd0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
